// File: rtl/vga_stream_driver.sv
// vga_stream_driver: VGA / ADV7123 scan-out engine. Buffers pixels in a small
// sync FIFO with watermark refill requests, generates sync/DE/DAC controls with
// one cycle of output latency, and offers a built-in 8-bar colour pattern.
module vga_stream_driver #(
  parameter int   H_SYNC         = 96,
  parameter int   H_BP           = 48,
  parameter int   H_ACT          = 640,
  parameter int   H_FP           = 16,
  parameter int   V_SYNC         = 2,
  parameter int   V_BP           = 33,
  parameter int   V_ACT          = 480,
  parameter int   V_FP           = 10,
  parameter logic HS_POL         = 1'b0,
  parameter logic VS_POL         = 1'b0,
  parameter int   PIX_FMT        = 0,
  parameter int   FIFO_AW        = 4,
  parameter int   LO_WM          = 4,
  parameter int   HI_WM          = 12,
  parameter int   FLUSH_ON_FRAME = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] din,
  input  logic        din_vld,
  output logic        req,
  input  logic        pat_en,
  input  logic        err_clr,
  output logic        underflow,
  output logic        overflow,
  output logic        frame_start,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_blank,
  output logic        vga_sync,
  output logic        vga_clk,
  output logic        hsync,
  output logic        vsync
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int BAR_W   = H_ACT / 8;
  localparam int BCW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0]    H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]    H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0]    H_ACT_BEG  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0]    H_ACT_END  = HW'(H_SYNC + H_BP + H_ACT);
  localparam logic [VW-1:0]    V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]    V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0]    V_ACT_BEG  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0]    V_ACT_END  = VW'(V_SYNC + V_BP + V_ACT);
  localparam logic [FIFO_AW:0] FULL_LVL   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LO_LVL     = (FIFO_AW + 1)'(LO_WM);
  localparam logic [FIFO_AW:0] HI_LVL     = (FIFO_AW + 1)'(HI_WM);
  localparam logic [BCW-1:0]   BAR_LAST   = BCW'(BAR_W - 1);

  // Expand RGB565 to 8 bits per channel by replicating the MSBs.
  function automatic logic [23:0] map565(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  // Colour of each test-pattern bar, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  logic [HW-1:0]    cnt_h_q, cnt_h_d;
  logic [VW-1:0]    cnt_v_q, cnt_v_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [23:0]      mem_q [DEPTH];
  logic [23:0]      rgb_q, rgb_d;
  logic [2:0]       bar_q, bar_d;
  logic [BCW-1:0]   bar_cnt_q, bar_cnt_d;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic             req_q, req_d, uf_q, uf_d, of_q, of_d, pat_mode_q, pat_mode_d;

  logic [FIFO_AW:0] usedw_s;
  logic [23:0]      pix_s, fmt_rgb_s;
  logic             active_s, fs_s, flush_s, full_s, empty_s, wr_s, rd_s;

  assign usedw_s   = wr_ptr_q - rd_ptr_q;
  assign full_s    = (usedw_s == FULL_LVL);
  assign empty_s   = (usedw_s == '0);
  assign fs_s      = (cnt_h_q == '0) && (cnt_v_q == '0);
  assign flush_s   = fs_s && (FLUSH_ON_FRAME != 0);
  assign active_s  = (cnt_h_q >= H_ACT_BEG) && (cnt_h_q < H_ACT_END) &&
                     (cnt_v_q >= V_ACT_BEG) && (cnt_v_q < V_ACT_END);
  // full is judged before any same-cycle read, so a read never makes room for a write.
  assign wr_s      = din_vld && !full_s && !flush_s;
  assign rd_s      = active_s && !empty_s && !pat_mode_q;
  assign pix_s     = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign fmt_rgb_s = (PIX_FMT == 1) ? pix_s : map565(pix_s[15:0]);

  // Next-state for timing counters, FIFO pointers, flags, pattern and pixel outputs.
  always_comb begin
    cnt_h_d    = cnt_h_q;
    cnt_v_d    = cnt_v_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    bar_d      = bar_q;
    bar_cnt_d  = bar_cnt_q;
    rgb_d      = 24'h000000;
    req_d      = req_q;

    if (cnt_h_q == H_LAST) begin
      cnt_h_d = '0;
      if (cnt_v_q == V_LAST) begin
        cnt_v_d = '0;
      end else begin
        cnt_v_d = cnt_v_q + 1'b1;
      end
    end else begin
      cnt_h_d = cnt_h_q + 1'b1;
    end

    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, wr_s};
      rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, rd_s};
    end

    // Bars restart at every active line; the last bar absorbs any remainder.
    if (!active_s) begin
      bar_d     = 3'd0;
      bar_cnt_d = '0;
    end else if (bar_q == 3'd7) begin
      bar_d     = bar_q;
    end else if (bar_cnt_q == BAR_LAST) begin
      bar_cnt_d = '0;
      bar_d     = bar_q + 3'd1;
    end else begin
      bar_cnt_d = bar_cnt_q + 1'b1;
    end

    if (!active_s) begin
      rgb_d = 24'h000000;
    end else if (pat_mode_q) begin
      rgb_d = bar_colour(bar_q);
    end else if (empty_s) begin
      rgb_d = 24'h000000;
    end else begin
      rgb_d = fmt_rgb_s;
    end

    if (usedw_s <= LO_LVL) begin
      req_d = 1'b1;
    end else if (usedw_s >= HI_LVL) begin
      req_d = 1'b0;
    end else begin
      req_d = req_q;
    end

    hs_d       = (cnt_h_q < H_SYNC_END) ? HS_POL : ~HS_POL;
    vs_d       = (cnt_v_q < V_SYNC_END) ? VS_POL : ~VS_POL;
    de_d       = active_s;
    fs_d       = fs_s;
    pat_mode_d = fs_s ? pat_en : pat_mode_q;
    // A set in the same cycle as err_clr wins.
    uf_d       = (active_s && empty_s && !pat_mode_q) ? 1'b1 : (err_clr ? 1'b0 : uf_q);
    of_d       = (din_vld && full_s && !flush_s) ? 1'b1 : (err_clr ? 1'b0 : of_q);
  end

  // State register with synchronous reset; reset restarts the frame with an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_h_q    <= '0;
      cnt_v_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      bar_q      <= 3'd0;
      bar_cnt_q  <= '0;
      rgb_q      <= 24'h000000;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      req_q      <= 1'b0;
      uf_q       <= 1'b0;
      of_q       <= 1'b0;
      pat_mode_q <= 1'b0;
    end else begin
      cnt_h_q    <= cnt_h_d;
      cnt_v_q    <= cnt_v_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      bar_q      <= bar_d;
      bar_cnt_q  <= bar_cnt_d;
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      de_q       <= de_d;
      fs_q       <= fs_d;
      req_q      <= req_d;
      uf_q       <= uf_d;
      of_q       <= of_d;
      pat_mode_q <= pat_mode_d;
    end
  end

  // FIFO storage array (no reset needed; validity is tracked by the pointers).
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
    end
  end

  assign req         = req_q;
  assign underflow   = uf_q;
  assign overflow    = of_q;
  assign frame_start = fs_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_blank   = de_q;
  assign vga_sync    = 1'b0;
  assign vga_clk     = ~clk;
  assign hsync       = hs_q;
  assign vsync       = vs_q;

endmodule

// File: tb/tb_vga_stream_driver.sv
// tb_vga_stream_driver: directed checks of timing, FIFO, flags, refill
// request and colour-bar pattern using a reduced 28x14 timing.
// k counts rising edges after reset release; after edge k the outputs
// reflect counter position k (linear h + 28*v within a 392-cycle frame).
module tb_vga_stream_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] din, din2;
  logic        din_vld, din_vld2, pat_en, pat_en2, err_clr, err_clr2;
  logic        req, underflow, overflow, frame_start;
  logic        req2, underflow2, overflow2, frame_start2;
  logic [7:0]  vga_r, vga_g, vga_b, vga_r2, vga_g2, vga_b2;
  logic        vga_blank, vga_sync, vga_clk, hsync, vsync;
  logic        vga_blank2, vga_sync2, vga_clk2, hsync2, vsync2;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = -1;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  vga_stream_driver #(
    .H_SYNC(4), .H_BP(4), .H_ACT(16), .H_FP(4),
    .V_SYNC(2), .V_BP(2), .V_ACT(8), .V_FP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_FMT(0),
    .FIFO_AW(4), .LO_WM(4), .HI_WM(12), .FLUSH_ON_FRAME(1)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .req(req),
    .pat_en(pat_en), .err_clr(err_clr), .underflow(underflow), .overflow(overflow),
    .frame_start(frame_start), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_blank(vga_blank), .vga_sync(vga_sync), .vga_clk(vga_clk),
    .hsync(hsync), .vsync(vsync)
  );

  vga_stream_driver #(
    .H_SYNC(4), .H_BP(4), .H_ACT(16), .H_FP(4),
    .V_SYNC(2), .V_BP(2), .V_ACT(8), .V_FP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_FMT(1),
    .FIFO_AW(4), .LO_WM(4), .HI_WM(12), .FLUSH_ON_FRAME(1)
  ) dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_vld(din_vld2), .req(req2),
    .pat_en(pat_en2), .err_clr(err_clr2), .underflow(underflow2), .overflow(overflow2),
    .frame_start(frame_start2), .vga_r(vga_r2), .vga_g(vga_g2), .vga_b(vga_b2),
    .vga_blank(vga_blank2), .vga_sync(vga_sync2), .vga_clk(vga_clk2),
    .hsync(hsync2), .vsync(vsync2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int t);
    while (k < t) tick();
  endtask

  initial begin
    rst = 1'b1; din = 24'h0; din_vld = 1'b0; pat_en = 1'b0; err_clr = 1'b0;
    din2 = 24'h123456; din_vld2 = 1'b0; pat_en2 = 1'b0; err_clr2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hsync", hsync, 1'b1);
    check_eq("rst_vsync", vsync, 1'b1);
    check_eq("rst_req", req, 1'b0);
    check_eq("rst_de", vga_blank, 1'b0);
    check_eq("rst_fs", frame_start, 1'b0);
    check_eq("rst_flags", {underflow, overflow}, 2'b00);
    check_eq("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
    check_eq("rst_sync_const", vga_sync, 1'b0);
    check_eq("rst_hsync2", hsync2, 1'b0);
    check_eq("rst_vsync2", vsync2, 1'b0);
    rst = 1'b0;

    // Timing after release; dut2 gets a single RGB888 word.
    run_to(0);
    check_eq("fs_first", frame_start, 1'b1);
    check_eq("req_after_rst", req, 1'b1);
    check_eq("hsync_k0", hsync, 1'b0);
    check_eq("vsync_k0", vsync, 1'b0);
    check_eq("hsync2_k0", hsync2, 1'b1);
    check_eq("vsync2_k0", vsync2, 1'b1);
    din_vld2 = 1'b1;
    run_to(1);  din_vld2 = 1'b0;
    check_eq("fs_k1", frame_start, 1'b0);
    run_to(3);  check_eq("hsync_k3", hsync, 1'b0);
    run_to(4);  check_eq("hsync_k4", hsync, 1'b1);
    check_eq("hsync2_k4", hsync2, 1'b0);
    run_to(55); check_eq("vsync_line1", vsync, 1'b0);
    run_to(56); check_eq("vsync_line2", vsync, 1'b1);
    check_eq("vsync2_line2", vsync2, 1'b0);

    // Underflow on first active pixel with FIFO empty.
    run_to(119);
    check_eq("de_pre_active", vga_blank, 1'b0);
    check_eq("uf_pre_active", underflow, 1'b0);
    run_to(120);
    check_eq("de_first_active", vga_blank, 1'b1);
    check_eq("rgb_underflow_black", {vga_r, vga_g, vga_b}, 24'h0);
    check_eq("uf_set", underflow, 1'b1);
    check_eq("rgb888_dut2", {vga_r2, vga_g2, vga_b2}, 24'h123456);
    run_to(135); err_clr = 1'b1;
    run_to(136); err_clr = 1'b0;
    check_eq("uf_cleared", underflow, 1'b0);
    run_to(147); check_eq("uf_still_clear", underflow, 1'b0);
    run_to(148); check_eq("uf_reset_next_pixel", underflow, 1'b1);

    // Frame 1: 12 words of red, watermark behaviour.
    run_to(391); check_eq("fs_k391", frame_start, 1'b0);
    run_to(392); check_eq("fs_period", frame_start, 1'b1);
    din = 24'h00F800; din_vld = 1'b1; err_clr = 1'b1;
    run_to(393); err_clr = 1'b0;
    check_eq("uf_clr2", underflow, 1'b0);
    run_to(404); din_vld = 1'b0;
    check_eq("req_usedw11", req, 1'b1);
    run_to(405); check_eq("req_drop_hi", req, 1'b0);
    run_to(511); check_eq("de_k511", vga_blank, 1'b0);
    run_to(512);
    check_eq("de_k512", vga_blank, 1'b1);
    check_eq("rgb565_red", {vga_r, vga_g, vga_b}, 24'hFF0000);
    run_to(519); check_eq("req_hold_usedw5", req, 1'b0);
    run_to(520); check_eq("req_rise_lo", req, 1'b1);
    run_to(523); check_eq("rgb_last_word", {vga_r, vga_g, vga_b}, 24'hFF0000);
    run_to(524);
    check_eq("rgb_after_drain", {vga_r, vga_g, vga_b}, 24'h0);
    check_eq("uf_after_drain", underflow, 1'b1);

    // Frame 2: 17 writes into an empty FIFO.
    run_to(784);
    din_vld = 1'b1;
    for (int i = 0; i < 17; i++) begin
      run_to(784 + i);
      din = 24'((i + 1) << 11);
    end
    check_eq("of_before_full", overflow, 1'b0);
    run_to(801); din_vld = 1'b0;
    check_eq("of_set", overflow, 1'b1);
    run_to(904); check_eq("ovf_word0", {vga_r, vga_g, vga_b}, 24'h080000);
    run_to(919); check_eq("ovf_word15", {vga_r, vga_g, vga_b}, 24'h840000);
    run_to(932); check_eq("ovf_word16_lost", {vga_r, vga_g, vga_b}, 24'h0);

    // Pattern enabled mid-frame: takes effect only at the next frame.
    run_to(940); pat_en = 1'b1;
    run_to(960);
    check_eq("pat_no_tear_rgb", {vga_r, vga_g, vga_b}, 24'h0);
    check_eq("pat_no_tear_de", vga_blank, 1'b1);
    run_to(1176);
    din = 24'h00F800; din_vld = 1'b1;
    run_to(1188); din_vld = 1'b0; err_clr = 1'b1;
    run_to(1189); err_clr = 1'b0;
    check_eq("req_pat_full", req, 1'b0);
    check_eq("uf_pat_clr", underflow, 1'b0);
    for (int j = 0; j < 16; j++) begin
      run_to(1296 + j);
      check_eq("pat_bar", {vga_r, vga_g, vga_b}, bars[j / 2]);
    end
    run_to(1320);
    check_eq("pat_no_reads", req, 1'b0);
    check_eq("pat_no_uf", underflow, 1'b0);
    run_to(1324); check_eq("pat_line_restart", {vga_r, vga_g, vga_b}, 24'hFFFFFF);

    // Mid-frame reset restarts timing, clears pattern mode and flags.
    run_to(1330);
    rst = 1'b1; pat_en = 1'b0;
    tick(); tick();
    check_eq("midrst_req", req, 1'b0);
    check_eq("midrst_de", vga_blank, 1'b0);
    check_eq("midrst_of", overflow, 1'b0);
    rst = 1'b0;
    k = -1;
    tick();
    check_eq("midrst_fs", frame_start, 1'b1);
    check_eq("midrst_req_rise", req, 1'b1);
    run_to(120);
    check_eq("midrst_pat_off", {vga_r, vga_g, vga_b}, 24'h0);
    check_eq("midrst_uf", underflow, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
